// File: rtl/lcd_st_timing_adapter.sv
// lcd_st_timing_adapter: Avalon-ST ready-latency adapter built around a show-ahead FIFO with overrun flag.
module lcd_st_timing_adapter #(
  parameter int DATA_W = 8,
  parameter int EMPTY_W = 1,
  parameter int CHANNEL_W = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int IN_READY_LATENCY = 0,
  parameter int OUT_READY_LATENCY = 0,
  parameter int FILL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 in_ready,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [EMPTY_W-1:0]   in_empty,
  input  logic [CHANNEL_W-1:0] in_channel,
  input  logic                 in_startofpacket,
  input  logic                 in_endofpacket,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic [EMPTY_W-1:0]   out_empty,
  output logic [CHANNEL_W-1:0] out_channel,
  output logic                 out_startofpacket,
  output logic                 out_endofpacket,
  output logic [FILL_W-1:0]    fill_level,
  output logic                 overflow_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = DATA_W + EMPTY_W + CHANNEL_W + 2;
  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic full, beat, wr, pop, rdy_ok, pop_en;
  assign full = fill_level == FILL_W'(FIFO_DEPTH);
  assign in_ready = !reset && fill_level <= FILL_W'(FIFO_DEPTH - 1 - IN_READY_LATENCY);
  assign beat = in_valid && (IN_READY_LATENCY == 0 ? in_ready : 1'b1);
  assign out_valid = rdy_ok && fill_level != '0;
  assign pop = out_valid && pop_en;
  // a pop in the same cycle frees the slot, so a full FIFO can still take the beat
  assign wr = beat && (!full || pop);
  assign {out_data, out_empty, out_channel, out_startofpacket, out_endofpacket} = mem[rd_ptr];
  if (OUT_READY_LATENCY == 0) begin : g_rl0
    assign rdy_ok = 1'b1;
    assign pop_en = out_ready;
  end else begin : g_rl
    logic [OUT_READY_LATENCY-1:0] rdy_d;
    always_ff @(posedge clk or posedge reset)
      if (reset) rdy_d <= '0;
      else rdy_d <= OUT_READY_LATENCY'({rdy_d, out_ready});
    assign rdy_ok = rdy_d[OUT_READY_LATENCY-1];
    assign pop_en = 1'b1;
  end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= {in_data, in_empty, in_channel, in_startofpacket, in_endofpacket};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_level <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr && !pop) fill_level <= fill_level + FILL_W'(1);
      else if (pop && !wr) fill_level <= fill_level - FILL_W'(1);
      if (beat && full && !pop) overflow_err <= 1'b1;
    end
endmodule

// File: tb/tb_lcd_st_timing_adapter.sv
// tb_lcd_st_timing_adapter: scoreboard bench for a latency-0 instance and an in-latency-2/out-latency-3 instance.
module tb_lcd_st_timing_adapter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic a_in_ready, a_in_valid, a_in_sop, a_in_eop, a_out_ready, a_out_valid, a_out_sop, a_out_eop, a_ovf;
  logic [7:0] a_in_data, a_out_data;
  logic [0:0] a_in_empty, a_in_channel, a_out_empty, a_out_channel;
  logic [3:0] a_fill;
  logic b_in_ready, b_in_valid, b_in_sop, b_in_eop, b_out_ready, b_out_valid, b_out_sop, b_out_eop, b_ovf;
  logic [7:0] b_in_data, b_out_data;
  logic [0:0] b_in_empty, b_in_channel, b_out_empty, b_out_channel;
  logic [3:0] b_fill;

  lcd_st_timing_adapter u_a (
    .clk(clk), .reset(rst), .in_ready(a_in_ready), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_empty(a_in_empty), .in_channel(a_in_channel), .in_startofpacket(a_in_sop), .in_endofpacket(a_in_eop),
    .out_ready(a_out_ready), .out_valid(a_out_valid), .out_data(a_out_data), .out_empty(a_out_empty),
    .out_channel(a_out_channel), .out_startofpacket(a_out_sop), .out_endofpacket(a_out_eop),
    .fill_level(a_fill), .overflow_err(a_ovf)
  );

  lcd_st_timing_adapter #(.IN_READY_LATENCY(2), .OUT_READY_LATENCY(3)) u_b (
    .clk(clk), .reset(rst), .in_ready(b_in_ready), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_empty(b_in_empty), .in_channel(b_in_channel), .in_startofpacket(b_in_sop), .in_endofpacket(b_in_eop),
    .out_ready(b_out_ready), .out_valid(b_out_valid), .out_data(b_out_data), .out_empty(b_out_empty),
    .out_channel(b_out_channel), .out_startofpacket(b_out_sop), .out_endofpacket(b_out_eop),
    .fill_level(b_fill), .overflow_err(b_ovf)
  );

  int compared = 0;
  int mismatched = 0;
  logic [11:0] qa[$];
  logic [11:0] qb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] mk(input logic [7:0] d, input logic s, input logic e);
    return {d, d[0], d[1], s, e};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [11:0] w);
    {a_in_data, a_in_empty, a_in_channel, a_in_sop, a_in_eop} = w;
    a_in_valid = v;
  endtask

  task automatic drive_b(input logic v, input logic [11:0] w);
    {b_in_data, b_in_empty, b_in_channel, b_in_sop, b_in_eop} = w;
    b_in_valid = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    qa.delete();
    qb.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain_b();
    b_out_ready = 1'b1;
    for (int i = 0; i < 40 && qb.size() != 0; i++) tick();
    chk("b_drain_left", qb.size(), 0);
    b_out_ready = 1'b0;
  endtask

  // monitors: compare every popped beat against the oldest expected beat
  always @(negedge clk) begin
    logic [11:0] w;
    if (a_out_valid && a_out_ready) begin
      w = {a_out_data, a_out_empty, a_out_channel, a_out_sop, a_out_eop};
      if (qa.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL a_unexpected: got %0h, expected no beat", w);
      end else chk("a_beat", w, qa.pop_front());
    end
    if (b_out_valid) begin
      w = {b_out_data, b_out_empty, b_out_channel, b_out_sop, b_out_eop};
      if (qb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL b_unexpected: got %0h, expected no beat", w);
      end else chk("b_beat", w, qb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] w;
    logic [1:0] h;
    int sent, drop_fill;
    drive_a(1'b0, '0);
    drive_b(1'b0, '0);
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
    #2;
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_fill", a_fill, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_b_in_ready", b_in_ready, 0);
    @(posedge clk);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", a_in_ready, 1);
    tick();
    // 20-beat packet through the latency-0 instance
    a_out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      w = mk(8'(i), i == 0, i == 19);
      drive_a(1'b1, w);
      qa.push_back(w);
      tick();
      chk("t1_valid", a_out_valid, 1);
      chk("t1_fill_le1", a_fill <= 4'd1, 1);
    end
    drive_a(1'b0, '0);
    tick();
    chk("t1_fill_end", a_fill, 0);
    chk("t1_left", qa.size(), 0);
    a_out_ready = 1'b0;
    // in-latency-2 source obeying in_ready, sink stalled
    h = 2'b00;
    sent = 0;
    drop_fill = -1;
    for (int t = 0; t < 14; t++) begin
      if (!b_in_ready && drop_fill < 0) drop_fill = int'(b_fill);
      w = mk(8'(8'h40 + sent), sent == 0, 1'b0);
      drive_b(h[1], w);
      if (h[1]) begin
        qb.push_back(w);
        sent++;
      end
      h = {h[0], b_in_ready};
      tick();
    end
    drive_b(1'b0, '0);
    chk("t2_sent", sent, 8);
    chk("t2_drop_fill", drop_fill, 6);
    chk("t2_fill", b_fill, 8);
    chk("t2_ovf", b_ovf, 0);
    // one extra beat ignoring in_ready overruns the full FIFO
    drive_b(1'b1, mk(8'hEE, 1'b0, 1'b1));
    tick();
    drive_b(1'b0, '0);
    chk("t3_ovf", b_ovf, 1);
    chk("t3_fill", b_fill, 8);
    tick();
    tick();
    tick();
    chk("t3_ovf_held", b_ovf, 1);
    drain_b();
    chk("t3_fill_drained", b_fill, 0);
    chk("t3_ovf_after_drain", b_ovf, 1);
    // out latency 3: two-cycle ready pulse releases exactly two beats
    do_reset();
    chk("t4_ovf_cleared", b_ovf, 0);
    for (int k = 0; k < 4; k++) begin
      w = mk(8'(8'h60 + k), k == 0, k == 3);
      drive_b(1'b1, w);
      qb.push_back(w);
      tick();
    end
    drive_b(1'b0, '0);
    tick();
    tick();
    chk("t4_fill4", b_fill, 4);
    for (int j = 0; j < 8; j++) begin
      b_out_ready = j < 2;
      chk($sformatf("t4_valid_%0d", j), b_out_valid, (j == 3 || j == 4));
      tick();
    end
    b_out_ready = 1'b0;
    chk("t4_fill2", b_fill, 2);
    drain_b();
    chk("t4_fill_end", b_fill, 0);
    // full FIFO with write and pop together across the pointer wrap
    do_reset();
    for (int k = 0; k < 8; k++) begin
      w = mk(8'(8'h80 + k), k == 0, 1'b0);
      drive_b(1'b1, w);
      qb.push_back(w);
      tick();
    end
    drive_b(1'b0, '0);
    chk("t5_full", b_fill, 8);
    b_out_ready = 1'b1;
    for (int n = 0; n < 10 && !b_out_valid; n++) tick();
    chk("t5_valid_wait", b_out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      w = mk(8'(8'h90 + k), 1'b0, k == 4);
      drive_b(1'b1, w);
      qb.push_back(w);
      tick();
      chk("t5_fill_hold", b_fill, 8);
    end
    drive_b(1'b0, '0);
    drain_b();
    chk("t5_ovf", b_ovf, 0);
    chk("t5_fill_end", b_fill, 0);
    // reset mid-packet discards buffered beats
    do_reset();
    for (int k = 0; k < 5; k++) begin
      w = mk(8'(8'hA0 + k), k == 0, 1'b0);
      drive_a(1'b1, w);
      qa.push_back(w);
      tick();
    end
    drive_a(1'b0, '0);
    chk("t6_fill5", a_fill, 5);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", a_out_valid, 0);
    chk("t6_async_fill", a_fill, 0);
    chk("t6_async_in_ready", a_in_ready, 0);
    qa.delete();
    qb.delete();
    tick();
    rst = 1'b0;
    #1;
    chk("t6_rel_fill", a_fill, 0);
    chk("t6_rel_in_ready", a_in_ready, 1);
    tick();
    a_out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      chk("t6_no_stale", a_out_valid, 0);
      tick();
    end
    a_out_ready = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/lcd_st_timing_adapter.md
# lcd_st_timing_adapter

Parametrised Avalon-ST timing adapter that bridges a source and a sink with independent ready latencies, data/empty/channel widths and buffer depth. It buffers beats in an internal show-ahead FIFO, carries packet framing, empty and channel fields unchanged, and flags protocol overruns. It is the general replacement for the fixed 8-bit, latency-0 FIFO-to-sequencer adapters in the LCD/display pipeline.

## Interface
- DATA_W, 8, payload width in bits
- EMPTY_W, 1, width of empty field (unused symbols in the end-of-packet beat)
- CHANNEL_W, 1, width of channel field
- FIFO_DEPTH, 8, entries; power of 2, 2..256; must exceed IN_READY_LATENCY
- IN_READY_LATENCY, 0, ready latency of the upstream source, 0..4
- OUT_READY_LATENCY, 0, ready latency of the downstream sink, 0..4
- FILL_W, derived, log2(FIFO_DEPTH)+1

- clk  in  1  sole clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- in_ready  out  1  adapter can accept beats (interpreted per IN_READY_LATENCY)
- in_valid  in  1  beat present on in_*
- in_data  in  DATA_W  payload
- in_empty  in  EMPTY_W  empty field
- in_channel  in  CHANNEL_W  channel field
- in_startofpacket, in_endofpacket  in  1 each  framing
- out_ready  in  1  sink ready (interpreted per OUT_READY_LATENCY)
- out_valid  out  1  beat present on out_*
- out_data, out_empty, out_channel, out_startofpacket, out_endofpacket  out  matching widths  payload fields
- fill_level  out  FILL_W  stored entries
- overflow_err  out  1  sticky: a beat arrived while the FIFO was full

## Operation
- Payload word = {data, empty, channel, sop, eop}, stored and returned bit-exact; no field is interpreted or modified.
- Input acceptance: IN_READY_LATENCY = 0: a beat is written when in_valid & in_ready. IN_READY_LATENCY = L > 0: every cycle with in_valid is a beat, legal only if in_ready was high L cycles earlier.
- in_ready = (fill_level <= FIFO_DEPTH-1-IN_READY_LATENCY), combinational from the registered count; forced 0 while reset is asserted. This guarantees space for up to L in-flight beats.
- Overrun: a beat arriving with fill_level = FIFO_DEPTH and no pop in the same cycle is dropped and sets overflow_err; it stays set until reset.
- Output: show-ahead FIFO; head entry always drives out_* fields.
- OUT_READY_LATENCY = 0: out_valid = (fill_level != 0); pop on out_valid & out_ready.
- OUT_READY_LATENCY = M > 0: out_ready delayed through an M-stage shift register (rdy_d). out_valid = rdy_d[M-1] & (fill_level != 0); pop when out_valid. out_valid never asserts unless out_ready was high exactly M cycles before.
- Simultaneous write and pop: both performed, fill_level unchanged; legal when full (pop frees the slot for the write).
- Write/read pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. fill_level is a separate counter: +1 on write only, -1 on pop only.
- Reset (any time, including mid-packet): pointers, fill_level, rdy_d and overflow_err cleared; buffered beats discarded. No packet repair is performed.

## Timing
- Reset values: in_ready 0, out_valid 0, fill_level 0, overflow_err 0. out_* payload is don't-care while out_valid = 0.
- After reset deasserts, in_ready = 1 in the same cycle (fill 0).
- Latency with empty FIFO and OUT_READY_LATENCY = 0: a beat written at edge N appears with out_valid = 1 after edge N; no combinational in-to-out path.
- OUT_READY_LATENCY = M: first out_valid is no earlier than M cycles after out_ready rises, and no earlier than 1 cycle after the write.
- Throughput: 1 beat/cycle sustained on both sides when neither side stalls.
- fill_level and overflow_err update on the clock edge of the causing event.

## Test plan
- Defaults, 20 beats 0x00..0x13 with sop on the first and eop on the last, out_ready = 1 -> identical sequence out, 1/cycle, 1-cycle latency, fill_level never exceeds 1.
- FIFO_DEPTH = 8, IN_READY_LATENCY = 2, out_ready = 0, continuous source -> in_ready drops when fill_level reaches 6; exactly 8 beats are stored; overflow_err stays 0.
- Same configuration with the source ignoring in_ready for 1 extra beat -> 9th beat dropped, overflow_err = 1 and held; the 8 stored beats drain intact.
- OUT_READY_LATENCY = 3, FIFO holding 4 beats, out_ready pulsed high for 2 cycles at cycle 10 -> out_valid high at cycles 13 and 14 only; fill_level goes 4 -> 2.
- Full FIFO with simultaneous write and pop for 5 cycles -> fill_level stays 8, order preserved across the pointer wrap, no overflow.
- Reset asserted mid-packet with 5 beats stored -> outputs take reset values asynchronously; after release fill_level = 0 and no stale beat is emitted.
